// File: rtl/out_sched.sv
// Output-port scheduler for the 4x4 wormhole switch: round-robin packet grant
// held from head to tail, with credit-gated flit forwarding to the downstream buffer.
module out_sched #(
    parameter int N       = 4,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [1:0]    ftype,
    input  logic          cred_in,
    output logic [N-1:0]  ack,
    output logic          go,
    output logic [CW-1:0] credit,
    output logic          err
);
    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [N-1:0]    ack_r, ack_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [IW-1:0]   pick_s;
    logic            found_s;
    logic [CW-1:0]   credit_r, credit_s;
    logic            err_r, err_s;
    logic            go_s;

    // Round-robin search starting at the pointer; index arithmetic wraps mod N.
    always_comb begin
        pick_s  = ptr_r;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && req[ptr_r + IW'(k)]) begin
                found_s = 1'b1;
                pick_s  = ptr_r + IW'(k);
            end else begin
                pick_s  = pick_s;
            end
        end
    end

    // Transfer strobe; reset masks it so the input buffer never dequeues during reset.
    always_comb begin
        go_s = (!rst) && (state_r == BUSY) && (ftype != 2'b00) && (credit_r != {CW{1'b0}});
    end

    // Grant FSM next state: grant on request in IDLE, release after a forwarded tail.
    always_comb begin
        state_s = state_r;
        ack_s   = ack_r;
        ptr_s   = ptr_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = BUSY;
                    ack_s   = {{(N-1){1'b0}}, 1'b1} << pick_s;
                    idx_s   = pick_s;
                end else begin
                    ack_s   = {N{1'b0}};
                end
            end
            BUSY: begin
                if (go_s && (ftype == 2'b11)) begin
                    state_s = IDLE;
                    ack_s   = {N{1'b0}};
                    ptr_s   = idx_r + IW'(1);
                end else begin
                    ack_s   = ack_r;
                end
            end
            default: begin
                state_s = IDLE;
                ack_s   = {N{1'b0}};
            end
        endcase
    end

    // Credit counter next value; a return into a full counter saturates and flags an error.
    always_comb begin
        credit_s = credit_r;
        err_s    = err_r;
        if (go_s && !cred_in) begin
            credit_s = credit_r - CW'(1);
        end else if (cred_in && !go_s) begin
            if (credit_r == CW'(CREDITS)) begin
                err_s    = 1'b1;
            end else begin
                credit_s = credit_r + CW'(1);
            end
        end else begin
            credit_s = credit_r;
        end
    end

    // State, grant and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            ack_r    <= {N{1'b0}};
            ptr_r    <= {IW{1'b0}};
            idx_r    <= {IW{1'b0}};
            credit_r <= CW'(CREDITS);
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            ack_r    <= ack_s;
            ptr_r    <= ptr_s;
            idx_r    <= idx_s;
            credit_r <= credit_s;
            err_r    <= err_s;
        end
    end

    assign ack    = ack_r;
    assign go     = go_s;
    assign credit = credit_r;
    assign err    = err_r;

endmodule

// File: tb/tb_out_sched.sv
// Self-checking bench for out_sched: directed scenarios followed by random traffic,
// all compared against a packet-level reference model.
module tb_out_sched;
    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] ftype = 2'b00;
    logic       cred_in = 1'b0;
    logic [3:0] ack;
    logic       go;
    logic [2:0] credit;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: owner of the port (-1 = idle), next search start, credits, error.
    int m_owner;
    int m_ptr;
    int m_credit;
    bit m_err;

    out_sched #(.N(4), .CREDITS(CREDITS), .CW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .ftype(ftype),
        .cred_in(cred_in), .ack(ack), .go(go), .credit(credit), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_ack();
        if (m_owner < 0) return 4'b0000;
        else return 4'(1 << m_owner);
    endfunction

    function automatic void model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_credit = CREDITS;
        m_err    = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic [1:0] ft,
                                       input logic ci, input logic g);
        m_credit = m_credit + int'(ci) - int'(g);
        if (m_credit > CREDITS) begin
            m_credit = CREDITS;
            m_err    = 1'b1;
        end
        if (m_owner >= 0) begin
            if (g && ft == 2'b11) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
    endfunction

    // Apply one cycle of inputs, compare all outputs before the edge, then advance the model.
    task automatic step(input logic [3:0] r, input logic [1:0] ft, input logic ci);
        logic exp_go;
        @(negedge clk);
        req = r; ftype = ft; cred_in = ci;
        #1;
        exp_go = (m_owner >= 0) && (ft != 2'b00) && (m_credit > 0);
        check("ack", 8'(ack), 8'(m_ack()));
        check("go", 8'(go), 8'(exp_go));
        check("credit", 8'(credit), 8'(m_credit));
        check("err", 8'(err), 8'(m_err));
        model_edge(r, ft, ci, exp_go);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b0000; ftype = 2'b00; cred_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset then idle.
        for (int i = 0; i < 5; i++) step(4'b0000, 2'b00, 1'b0);

        // Single packet from input 1: head, body, tail.
        step(4'b0010, 2'b00, 1'b0);
        step(4'b0000, 2'b01, 1'b0);
        check("single_ack", 8'(ack), 8'h02);
        step(4'b0000, 2'b10, 1'b0);
        step(4'b0000, 2'b11, 1'b0);
        step(4'b0000, 2'b00, 1'b0);
        check("single_credit", 8'(credit), 8'd1);
        check("single_release", 8'(ack), 8'h00);
        for (int i = 0; i < 3; i++) step(4'b0000, 2'b00, 1'b1);
        // Pointer now at 2: with everyone requesting, input 2 wins.
        step(4'b1111, 2'b00, 1'b0);
        step(4'b1111, 2'b11, 1'b1);
        check("rr_after_single", 8'(ack), 8'h04);
        step(4'b0000, 2'b00, 1'b0);

        // Round-robin from reset with all inputs requesting, 2-flit packets.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(4'b1111, 2'b00, 1'b0);
            step(4'b1111, 2'b01, 1'b1);
            check("rr_order", 8'(ack), 8'(1 << (p % 4)));
            step(4'b1111, 2'b11, 1'b1);
        end
        step(4'b0000, 2'b00, 1'b0);

        // Credit stall on a 6-flit packet with no returns.
        step(4'b0001, 2'b00, 1'b0);
        step(4'b0000, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 2'b10, 1'b0);
        step(4'b0000, 2'b10, 1'b0);
        check("stall_go", 8'(go), 8'd0);
        check("stall_credit", 8'(credit), 8'd0);
        check("stall_ack", 8'(ack), 8'h01);
        step(4'b0000, 2'b10, 1'b1);
        step(4'b0000, 2'b10, 1'b0);
        check("resume_go", 8'(go), 8'd1);
        check("resume_credit", 8'(credit), 8'd1);
        step(4'b0000, 2'b11, 1'b1);
        step(4'b0000, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 2'b00, 1'b1);

        // go and cred_in together at credit 2, then overflow while idle.
        step(4'b0100, 2'b00, 1'b0);
        step(4'b0000, 2'b01, 1'b0);
        step(4'b0000, 2'b10, 1'b0);
        step(4'b0000, 2'b10, 1'b1);
        step(4'b0000, 2'b11, 1'b0);
        check("simul_credit", 8'(credit), 8'd2);
        for (int i = 0; i < 3; i++) step(4'b0000, 2'b00, 1'b1);
        step(4'b0000, 2'b00, 1'b1);
        step(4'b0000, 2'b00, 1'b0);
        check("ovf_err", 8'(err), 8'd1);
        check("ovf_credit", 8'(credit), 8'd4);
        step(4'b0000, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a body flit.
        step(4'b1000, 2'b00, 1'b0);
        step(4'b0000, 2'b01, 1'b0);
        step(4'b0000, 2'b10, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_ack", 8'(ack), 8'h00);
        check("arst_go", 8'(go), 8'd0);
        check("arst_credit", 8'(credit), 8'd4);
        check("arst_err", 8'(err), 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; ftype = 2'b00;

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_sched.md
Name: out_sched

Overview:
- Per-output-port scheduler for the 4x4 wormhole switch. One instance per output port.
- Arbitrates that port among the four input buffers with round-robin fairness.
- Holds the grant for a whole packet, head flit through tail flit.
- Gates flit forwarding with a credit counter tracking free slots in the downstream buffer.
- Its one-hot grant drives the crossbar select and the input-buffer dequeue for that output.

Parameters:
- N, 4, number of requesting inputs. Fixed at 4 for this switch.
- CREDITS, 4, downstream buffer depth; reset value of the credit counter.
- CW, 3, credit counter width; must hold CREDITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  req[i] high: input buffer i has a head-of-queue flit destined for this port.
- ftype  input  2  type bits [9:8] of the flit on this crossbar output: 00 empty, 01 head, 10 body, 11 tail.
- cred_in  input  1  one-cycle pulse: downstream freed one slot.
- ack  output  N  registered one-hot grant; all zero when idle.
- go  output  1  combinational transfer strobe: a flit moves this cycle.
- credit  output  CW  current credit count.
- err  output  1  sticky error flag.

Behaviour:
- Reset (async, immediate):
  - ack = 0, state = IDLE, rr_ptr = 0.
  - credit = CREDITS, err = 0.
  - go is forced low while rst is high.
- State IDLE:
  - ack = 0.
  - If req != 0 at a rising edge, select the first i with req[i] = 1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - Set ack = one-hot(i) and move to BUSY.
  - Latency: req rising before edge t gives ack high after edge t (1 cycle).
- State BUSY:
  - ack is held constant.
  - Changes in req are ignored, including deassertion by the granted input.
- Transfer condition:
  - go = (state == BUSY) and (ftype != 00) and (credit != 0).
  - go is combinational, so the input buffer dequeues in the same cycle.
- Credit counter:
  - go without cred_in: credit - 1.
  - cred_in without go: credit + 1.
  - go and cred_in in the same cycle: credit unchanged.
  - Credit can never go below 0, because go requires credit != 0.
  - Overflow: cred_in with credit == CREDITS and no go leaves credit = CREDITS (saturates) and sets err = 1 (sticky until reset).
- Credit stall: while credit == 0 in BUSY, go stays low and the grant is held. Forwarding resumes the cycle after a cred_in raises credit.
- End of packet: go with ftype == 11 (tail) at edge t:
  - After edge t: state = IDLE, ack = 0, rr_ptr = (granted index + 1) mod N.
  - At least one idle cycle separates packets on the same port. The earliest next grant is after edge t+1.
- Flit-type rules:
  - Head or body flits in BUSY do not end the packet.
  - Empty flits (00) in BUSY consume no credit; the grant is held indefinitely.
- Protocol: ftype is only meaningful while ack != 0. In IDLE, ftype is ignored, go = 0, and credit changes only via cred_in.
- Reset mid-packet: the grant is dropped immediately and credits reload to CREDITS. Recovering upstream and downstream buffers is the system's responsibility.
- Round-robin fairness: with all requesters continuously asserting, grants cycle 0, 1, 2, 3, 0, ...

Test Plan:
- Reset then idle: rst pulse, req = 0 for 5 cycles -> ack = 0000, go = 0, credit = 4, err = 0 throughout.
- Single packet: req = 0010 -> ack = 0010 the next cycle. ftype sequence 01, 10, 11 -> go high 3 cycles, credit 4→1. ack = 0000 after the tail edge, and rr_ptr = 2.
- Round-robin: req = 1111 held, 2-flit packets, cred_in pulsed on every go -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between grants.
- Credit stall:
  - Setup: CREDITS = 4, 6-flit packet, no cred_in.
  - Required: go high for 4 flits, then low with ack held and credit = 0.
  - Then one cred_in pulse -> credit = 1, go resumes for the next flit.
- Simultaneous events:
  - go and cred_in in the same cycle at credit = 2 -> credit stays 2.
  - cred_in at credit = 4 while idle -> credit stays 4, err = 1 and stays set.
- Async reset mid-packet: rst asserted between edges during a body flit -> ack = 0000, go = 0, and credit = 4 immediately, without waiting for a clock edge.
